// File: rtl/symbol_tx_pkg.sv
// Shared types, sizes and helpers for the symbol transmit framer.
package symbol_tx_pkg;

    localparam int SYM_W      = 7;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [SYM_W-1:0] sym);
        return ^sym;
    endfunction

endpackage

// File: rtl/sym_fifo2.sv
// Two-entry synchronous FIFO holding symbol codes between the handshake and the serializer.
module sym_fifo2
    import symbol_tx_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       push_i,
    input  logic [6:0] din_i,
    input  logic       pop_i,
    output logic [6:0] dout_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    logic [6:0] mem_q [FIFO_DEPTH];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       push_ok;
    logic       pop_ok;

    assign full_o  = (count_q == 2'(FIFO_DEPTH));
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage carries no reset; only pointers and count define occupancy.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/symbol_tx_framer.sv
// Serializes buffered 7-bit symbol codes into UART-style frames on a single line.
module symbol_tx_framer
    import symbol_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int DROP_ZERO    = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [6:0] IN_DATA,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic       TX,
    output logic       BUSY,
    output logic       SENT
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [6:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             sent_q, sent_d;

    logic       fifo_full;
    logic       fifo_empty;
    logic [1:0] fifo_count;
    logic [6:0] fifo_head;
    logic       fifo_push;
    logic       fifo_pop;
    logic       drop_sym;
    logic       last_cyc;

    // Code 0 is still acknowledged upstream when dropped; it just never reaches the FIFO.
    assign IN_READY  = !fifo_full;
    assign drop_sym  = (DROP_ZERO != 0) && (IN_DATA == 7'd0);
    assign fifo_push = IN_VALID && IN_READY && !drop_sym;
    assign last_cyc  = (cnt_q == CNT_LAST);

    sym_fifo2 u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push_i  (fifo_push),
        .din_i   (IN_DATA),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = last_cyc ? '0 : cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = 3'd0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    par_d    = even_parity(fifo_head);
                    state_d  = START;
                end
            end
            START: begin
                if (last_cyc) begin
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (last_cyc) begin
                    shift_d = {1'b0, shift_q[6:1]};
                    if (bit_q == 3'd6) begin
                        bit_d   = 3'd0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (last_cyc) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Back-to-back frames reload straight into START with no idle cycle.
                if (last_cyc) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        par_d    = even_parity(fifo_head);
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line outputs are registered one cycle behind the state so TX, SENT and BUSY stay aligned.
    always_comb begin
        tx_d   = 1'b1;
        sent_d = (state_q == STOP) && last_cyc;
        busy_d = (state_q != IDLE) || (fifo_count != 2'd0);
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            PARITY:  tx_d = par_q;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 7'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            sent_q  <= sent_d;
        end
    end

    assign TX   = tx_q;
    assign BUSY = busy_q;
    assign SENT = sent_q;

endmodule

// File: tb/tb_symbol_tx_framer.sv
// Bench for symbol_tx_framer: three parameter variants checked cycle by cycle against a frame-level model.
module tb_symbol_tx_framer;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [6:0] in_data;
    logic       in_valid;
    int         sel;
    int         pe;
    int         dz;

    logic v0, v1, v2;
    logic r0, r1, r2, t0, t1, t2, b0, b1, b2, s0, s1, s2;
    logic obs_rdy, obs_tx, obs_busy, obs_sent;

    assign v0 = in_valid && (sel == 0);
    assign v1 = in_valid && (sel == 1);
    assign v2 = in_valid && (sel == 2);

    symbol_tx_framer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .DROP_ZERO(1)) dut (
        .CLK(clk), .RESET(rst), .IN_DATA(in_data), .IN_VALID(v0),
        .IN_READY(r0), .TX(t0), .BUSY(b0), .SENT(s0)
    );
    symbol_tx_framer #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .DROP_ZERO(1)) dut_np (
        .CLK(clk), .RESET(rst), .IN_DATA(in_data), .IN_VALID(v1),
        .IN_READY(r1), .TX(t1), .BUSY(b1), .SENT(s1)
    );
    symbol_tx_framer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .DROP_ZERO(0)) dut_nz (
        .CLK(clk), .RESET(rst), .IN_DATA(in_data), .IN_VALID(v2),
        .IN_READY(r2), .TX(t2), .BUSY(b2), .SENT(s2)
    );

    always_comb begin
        case (sel)
            1:       begin obs_rdy = r1; obs_tx = t1; obs_busy = b1; obs_sent = s1; end
            2:       begin obs_rdy = r2; obs_tx = t2; obs_busy = b2; obs_sent = s2; end
            default: begin obs_rdy = r0; obs_tx = t0; obs_busy = b0; obs_sent = s0; end
        endcase
    end

    // Frame-level reference: each queued symbol owns a frame starting at a known edge.
    int         fr_push[$];
    int         fr_start[$];
    logic [6:0] fr_data[$];
    logic [6:0] stim_q[$];
    int         edge_n;
    int         last_end;
    int         sent_seen;
    int         frames_exp;
    logic       exp_rdy;
    logic       xfer;
    int         checks;
    int         errors;

    function automatic int flen();
        return (9 + pe) * CPB;
    endfunction

    function automatic logic frame_bit(input logic [6:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 7) return d[k-1];
        if (pe != 0 && k == 8) return ^d;
        return 1'b1;
    endfunction

    task automatic model_expect(input int e, output logic tx, output logic busy,
                                output logic sent, output logic rdy);
        int n;
        tx = 1'b1; busy = 1'b0; sent = 1'b0; n = 0;
        for (int i = 0; i < fr_start.size(); i++) begin
            int s = fr_start[i];
            int l = flen();
            if (e >= s && e < s + l) tx = frame_bit(fr_data[i], (e - s) / CPB);
            if (e == s + l - 1) sent = 1'b1;
            if (e >= fr_push[i] + 1 && e <= s + l - 1) busy = 1'b1;
            if (fr_push[i] <= e && s - 1 > e) n++;
        end
        rdy = (n < 2);
    endtask

    task automatic tick();
        logic e_tx, e_busy, e_sent, e_rdy;
        @(posedge clk);
        edge_n++;
        xfer = 1'b0;
        if (rst) begin
            fr_push.delete(); fr_start.delete(); fr_data.delete();
            last_end = 0;
        end else if (in_valid && exp_rdy) begin
            xfer = 1'b1;
            if (!(dz != 0 && in_data == 7'd0)) begin
                int s = edge_n + 2;
                if (last_end > s) s = last_end;
                fr_push.push_back(edge_n);
                fr_start.push_back(s);
                fr_data.push_back(in_data);
                last_end = s + flen();
                frames_exp++;
            end
        end
        @(negedge clk);
        model_expect(edge_n, e_tx, e_busy, e_sent, e_rdy);
        if (obs_sent === 1'b1) sent_seen++;
        checks++;
        assert (obs_tx === e_tx) else begin
            errors++; $error("FAIL tx edge=%0d got %b exp %b", edge_n, obs_tx, e_tx);
        end
        checks++;
        assert (obs_busy === e_busy) else begin
            errors++; $error("FAIL busy edge=%0d got %b exp %b", edge_n, obs_busy, e_busy);
        end
        checks++;
        assert (obs_sent === e_sent) else begin
            errors++; $error("FAIL sent edge=%0d got %b exp %b", edge_n, obs_sent, e_sent);
        end
        checks++;
        assert (obs_rdy === e_rdy) else begin
            errors++; $error("FAIL in_ready edge=%0d got %b exp %b", edge_n, obs_rdy, e_rdy);
        end
        exp_rdy = e_rdy;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_stream(input int gap_max);
        int budget = 20000;
        while (stim_q.size() > 0 && budget > 0) begin
            in_data  = stim_q[0];
            in_valid = (gap_max == 0) ? 1'b1 : ($urandom_range(0, gap_max) == 0);
            tick();
            if (xfer) void'(stim_q.pop_front());
            budget--;
        end
        in_valid = 1'b0;
        checks++;
        assert (stim_q.size() == 0) else begin
            errors++; $error("FAIL stream_timeout left=%0d exp 0", stim_q.size());
        end
    endtask

    task automatic check_sent(input string tag, input int base, input int want);
        checks++;
        assert (sent_seen - base == want) else begin
            errors++; $error("FAIL %s sent_pulses got %0d exp %0d", tag, sent_seen - base, want);
        end
    endtask

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; in_data = 7'd0;
        sel = 0; pe = 1; dz = 1;
        edge_n = 0; last_end = 0; sent_seen = 0; frames_exp = 0;
        exp_rdy = 1'b0; xfer = 1'b0; checks = 0; errors = 0;

        // Reset state held over idle cycles.
        do_reset();
        idle(20);

        // Single symbol 0x21.
        base = sent_seen;
        stim_q = '{7'h21};
        run_stream(0);
        idle(50);
        check_sent("single", base, 1);

        // Back-to-back stream with valid held high.
        base = sent_seen;
        stim_q = '{7'h21, 7'h7F, 7'h01};
        run_stream(0);
        idle(150);
        check_sent("b2b", base, 3);

        // Zero code dropped.
        base = sent_seen;
        stim_q = '{7'h00, 7'h05};
        run_stream(0);
        idle(100);
        check_sent("drop_zero", base, 1);

        // Zero code transmitted.
        sel = 2; pe = 1; dz = 0;
        do_reset();
        base = sent_seen;
        stim_q = '{7'h00, 7'h05};
        run_stream(0);
        idle(100);
        check_sent("keep_zero", base, 2);

        // No parity bit.
        sel = 1; pe = 0; dz = 1;
        do_reset();
        base = sent_seen;
        stim_q = '{7'h21};
        run_stream(0);
        idle(50);
        check_sent("no_parity", base, 1);

        // Reset during data bit 3, then a clean frame.
        sel = 0; pe = 1; dz = 1;
        do_reset();
        stim_q = '{7'h21, 7'h3C};
        run_stream(0);
        idle(16);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(10);
        base = sent_seen;
        stim_q = '{7'h55};
        run_stream(0);
        idle(50);
        check_sent("post_reset", base, 1);

        // Randomized traffic on every variant.
        for (int v = 0; v < 3; v++) begin
            sel = v;
            pe  = (v == 1) ? 0 : 1;
            dz  = (v == 2) ? 0 : 1;
            do_reset();
            base = sent_seen;
            frames_exp = 0;
            for (int k = 0; k < 30; k++) begin
                if ($urandom_range(0, 4) == 0) stim_q.push_back(7'd0);
                else stim_q.push_back(7'($urandom_range(0, 127)));
            end
            run_stream((v == 0) ? 0 : 30);
            idle(150);
            check_sent("random", base, frames_exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
